// File: rtl/dep_rule_cfg_ctrl.sv
// Deparser type-lookup rule configuration controller: assembles header + payload
// config words into a staged rule and commits it to the rule table with a one-hot strobe.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_cfg_valid/o_cfg_ready valid/ready handshake for config words
//   i_cfg_data, i_cfg_last  config word and end-of-packet marker
//   o_rule_wren            one-hot rule table write strobe (COMMIT only)
//   o_typeRule_valid       valid bit written with the rule
//   o_rule_data            staged rule payload
//   o_done                 one-cycle pulse per committed packet
//   o_err                  sticky error (overflow or bad index)
//   o_busy                 controller not idle
//   o_err_cnt              saturating error-packet count (DEP_CFG_ERR_CNT_EN only)
//
// Optional feature macro: DEP_CFG_ERR_CNT_EN

module dep_rule_cfg_ctrl #(
    parameter int RULE_NUM   = 8,
    parameter int RULE_WIDTH = 256,
    parameter int CFG_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [CFG_WIDTH-1:0]  i_cfg_data,
    input  logic                  i_cfg_last,
    output logic [RULE_NUM-1:0]   o_rule_wren,
    output logic                  o_typeRule_valid,
    output logic [RULE_WIDTH-1:0] o_rule_data,
    output logic                  o_done,
    output logic                  o_err,
    output logic                  o_busy
`ifdef DEP_CFG_ERR_CNT_EN
    ,
    output logic [7:0]            o_err_cnt
`endif
);

    localparam int PAYLOAD_WORDS = (RULE_WIDTH + CFG_WIDTH - 1) / CFG_WIDTH;
    localparam int STG_W         = PAYLOAD_WORDS * CFG_WIDTH;
    localparam int CNT_W         = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [8:0] RULE_NUM_W = 9'(RULE_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t               state;
    logic [7:0]           idx;
    logic                 vld;
    logic [STG_W-1:0]     stage;
    logic [CNT_W-1:0]     cnt;
    logic                 err;
    logic                 done;
    logic [RULE_NUM-1:0]  wren;

    logic                 accept;
    logic                 commit_go;
    logic [7:0]           commit_idx;
    logic                 commit_bad;
    logic                 commit_err;

    function automatic logic [RULE_NUM-1:0] idx_onehot(input logic [7:0] ix);
        logic [RULE_NUM-1:0] oh;
        oh = '0;
        for (int i = 0; i < RULE_NUM; i++) begin
            oh[i] = (ix == 8'(i));
        end
        return oh;
    endfunction

    assign o_cfg_ready = (state != S_COMMIT);
    assign accept      = i_cfg_valid & o_cfg_ready;

    // Every non-COMMIT state moves to COMMIT on an accepted last word.
    // A header-with-last commits the index arriving on the bus this cycle.
    assign commit_go  = accept & i_cfg_last;
    assign commit_idx = (state == S_IDLE) ? i_cfg_data[7:0] : idx;
    assign commit_bad = ({1'b0, commit_idx} >= RULE_NUM_W);
    assign commit_err = commit_bad | (state == S_DRAIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            vld   <= 1'b0;
            stage <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            wren  <= '0;
        end else begin
            done <= 1'b0;
            wren <= '0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        idx   <= i_cfg_data[7:0];
                        vld   <= i_cfg_data[CFG_WIDTH-1];
                        stage <= '0;
                        cnt   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        for (int w = 0; w < PAYLOAD_WORDS; w++) begin
                            if (cnt == CNT_W'(w)) begin
                                stage[w*CFG_WIDTH +: CFG_WIDTH] <= i_cfg_data;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        // Full payload seen but packet continues: overflow.
                        if (!i_cfg_last &&
                            (cnt == CNT_W'(PAYLOAD_WORDS - 1))) begin
                            state <= S_DRAIN;
                            err   <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (accept) begin
                        err <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (commit_go) begin
                state <= S_COMMIT;
                done  <= 1'b1;
                wren  <= idx_onehot(commit_idx);
                if (commit_err) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign o_rule_wren      = wren;
    assign o_typeRule_valid = vld;
    assign o_rule_data      = stage[RULE_WIDTH-1:0];
    assign o_done           = done;
    assign o_err            = err;
    assign o_busy           = (state != S_IDLE);

`ifdef DEP_CFG_ERR_CNT_EN
    logic [7:0] err_cnt;

    // One increment per erroneous packet, counted at its commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt <= '0;
        end else if (commit_go && commit_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_dep_rule_cfg_ctrl.sv
// Self-checking bench for dep_rule_cfg_ctrl: packet-level reference model
// compared every cycle, plus directed packets with literal expectations.

module tb_dep_rule_cfg_ctrl;

    localparam int RN = 8;
    localparam int RW = 256;
    localparam int CW = 32;
    localparam int PW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          last  = 1'b0;
    logic [CW-1:0] data  = '0;

    logic          ready;
    logic [RN-1:0] wren;
    logic          tvld;
    logic [RW-1:0] rdata;
    logic          done;
    logic          err;
    logic          busy;
`ifdef DEP_CFG_ERR_CNT_EN
    logic [7:0]    err_cnt;
    int            m_ecnt = 0;
`endif

    int checks = 0;
    int errors = 0;

    dep_rule_cfg_ctrl #(
        .RULE_NUM   (RN),
        .RULE_WIDTH (RW),
        .CFG_WIDTH  (CW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_cfg_valid      (valid),
        .o_cfg_ready      (ready),
        .i_cfg_data       (data),
        .i_cfg_last       (last),
        .o_rule_wren      (wren),
        .o_typeRule_valid (tvld),
        .o_rule_data      (rdata),
        .o_done           (done),
        .o_err            (err),
        .o_busy           (busy)
`ifdef DEP_CFG_ERR_CNT_EN
        ,
        .o_err_cnt        (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Packet-level reference: collect words, decide outcome at the last word.
    bit            m_ready = 1'b1;
    bit            m_in    = 1'b0;
    bit            m_commit = 1'b0;
    bit            m_err   = 1'b0;
    bit            m_vld   = 1'b0;
    bit            m_hvld  = 1'b0;
    int            m_n     = 0;
    logic [7:0]    m_idx   = '0;
    logic [RW-1:0] m_pay   = '0;
    logic [RW-1:0] m_hold  = '0;
    logic [RN-1:0] m_wren  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready  = 1'b1;
            m_in     = 1'b0;
            m_commit = 1'b0;
            m_err    = 1'b0;
            m_hvld   = 1'b0;
            m_hold   = '0;
            m_wren   = '0;
            m_n      = 0;
`ifdef DEP_CFG_ERR_CNT_EN
            m_ecnt   = 0;
`endif
        end else begin
            m_commit = 1'b0;
            m_wren   = '0;
            if (m_ready && valid) begin
                if (!m_in) begin
                    m_in  = 1'b1;
                    m_idx = data[7:0];
                    m_vld = data[CW-1];
                    m_pay = '0;
                    m_n   = 0;
                end else begin
                    if (m_n < PW) m_pay[m_n*CW +: CW] = data;
                    m_n++;
                end
                if (last) begin
                    m_in     = 1'b0;
                    m_commit = 1'b1;
                    if (m_idx < RN) m_wren = RN'(1 << m_idx);
                    if (m_idx >= RN || m_n > PW) begin
                        m_err = 1'b1;
`ifdef DEP_CFG_ERR_CNT_EN
                        if (m_ecnt < 255) m_ecnt++;
`endif
                    end
                    m_hold = m_pay;
                    m_hvld = m_vld;
                end
            end
            m_ready = !m_commit;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("ready", ready, m_ready);
        chk("busy", busy, m_in || m_commit);
        chk("done", done, m_commit);
        chk("wren", wren, m_wren);
        if (!(m_in && m_n >= PW)) chk("err", err, m_err);
        if (!m_in) begin
            chk("tvld", tvld, m_hvld);
            chk("rdata", rdata, m_hold);
        end
`ifdef DEP_CFG_ERR_CNT_EN
        chk("err_cnt", err_cnt, m_ecnt);
`endif
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [CW-1:0] d, input bit l,
                        output int stalls);
        bit r;
        stalls = 0;
        valid = 1'b1;
        data  = d;
        last  = l;
        forever begin
            r = ready;
            @(posedge clk);
            if (r) break;
            stalls++;
            if (stalls > 20) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout actual=stalled required=ready");
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic pkt(input logic [CW-1:0] hdr, input int n, input bit rnd,
                       input bit gaps, output int hstall);
        int s;
        send(hdr, n == 0, hstall);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            send(rnd ? $urandom : CW'((i + 1) * 32'h11), i == n - 1, s);
        end
    endtask

    task automatic do_reset();
        valid = 1'b0;
        last  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    int st;
    int st2;

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full 8-word packet to rule 3.
        pkt(32'h8000_0003, 8, 1'b0, 1'b0, st);
        chk("lit_wren3", wren, 8'h08);
        chk("lit_vld3", tvld, 1'b1);
        chk("lit_w0", rdata[31:0], 32'h11);
        chk("lit_w7", rdata[255:224], 32'h88);
        chk("lit_done3", done, 1'b1);
        chk("lit_err3", err, 1'b0);
        valid = 1'b0;
        @(negedge clk);

        // Header-only packet: valid-only update with zero payload.
        pkt(32'h0000_0001, 0, 1'b0, 1'b0, st);
        chk("lit_wren1", wren, 8'h02);
        chk("lit_vld1", tvld, 1'b0);
        chk("lit_zero", rdata, '0);
        valid = 1'b0;
        @(negedge clk);

        // Back-to-back packets with valid held high.
        pkt(32'h8000_0005, 3, 1'b0, 1'b0, st);
        chk("lit_wren5", wren, 8'h20);
        pkt(32'h8000_0006, 2, 1'b0, 1'b0, st2);
        chk("lit_stall", st2, 1);
        chk("lit_wren6", wren, 8'h40);
        chk("lit_w6", rdata[63:0], 64'h0000_0022_0000_0011);
        valid = 1'b0;
        @(negedge clk);

        // Reset after four payload words: packet discarded.
        send(32'h8000_0002, 1'b0, st);
        for (int i = 0; i < 4; i++) send(32'hA0 + i, 1'b0, st);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("lit_rst_wren", wren, '0);
        chk("lit_rst_busy", busy, 1'b0);
        chk("lit_rst_ready", ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pkt(32'h8000_0004, 8, 1'b0, 1'b0, st);
        chk("lit_wren4", wren, 8'h10);
        chk("lit_err4", err, 1'b0);
        valid = 1'b0;
        @(negedge clk);

        // Overflow: ten payload words, words 9-10 dropped.
        pkt(32'h8000_0001, 10, 1'b0, 1'b0, st);
        chk("lit_wren_ovf", wren, 8'h02);
        chk("lit_err_ovf", err, 1'b1);
        chk("lit_ovf_w7", rdata[255:224], 32'h88);
        valid = 1'b0;
        @(negedge clk);

        // Out-of-range index.
        pkt(32'h8000_0009, 8, 1'b0, 1'b0, st);
        chk("lit_wren_bad", wren, '0);
        chk("lit_done_bad", done, 1'b1);
        chk("lit_err_bad", err, 1'b1);
`ifdef DEP_CFG_ERR_CNT_EN
        chk("lit_ecnt", err_cnt, 8'd2);
`endif
        valid = 1'b0;
        @(negedge clk);

        // Randomized traffic, with occasional reset mid-packet.
        do_reset();
        for (int p = 0; p < 150; p++) begin
            logic [CW-1:0] hdr;
            hdr = $urandom;
            hdr[7:0] = 8'($urandom_range(0, 11));
            if ($urandom_range(0, 24) == 0) begin
                send(hdr, 1'b0, st);
                repeat ($urandom_range(0, 5)) send($urandom, 1'b0, st);
                do_reset();
            end else begin
                pkt(hdr, $urandom_range(0, 11), 1'b1, 1'b1, st);
                if ($urandom_range(0, 1) == 0) begin
                    valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
        end
        valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
